hdmi_line_read_sequencer: RTL and testbench
===========================================

# hdmi_line_read_sequencer

Frame-level controller for the HDMI pipelined Avalon read master. It splits each video frame into per-line bursts and computes every line's start address from a double-buffered frame base. For each line it re-arms the master (clear pulse, then start/address/length) and waits for the master's done. It sits between the HDMI timing/FIFO logic and the read master's control inputs.

## Interface
- LINE_BYTES, 2560: bytes fetched per line; multiple of 4, ≥ 4.
- STRIDE, 2560: byte distance between consecutive line start addresses.
- LINES, 480: lines per frame; 1..4095.
- iClk  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  run request; sampled only in IDLE and at end of line.
- iFrame_base  in  32  next frame buffer base; captured into shadow when iFrame_base_valid is 1.
- iFrame_base_valid  in  1  one-cycle strobe, new base available.
- iVsync  in  1  one-cycle frame-start pulse from the display timing block.
- iLine_req  in  1  level; display FIFO can accept one full line.
- iMaster_done  in  1  read master done; combinational and may last 1 cycle.
- oMaster_clr  out  1  one-cycle clear pulse to the master, ORed into its reset by the top level.
- oMaster_start  out  1  master start level.
- oStart_address  out  32  line start byte address.
- oLength  out  32  constant LINE_BYTES.
- oLine  out  12  index of the line in flight.
- oFrame_done  out  1  one-cycle pulse after the last line completes.
- oUnderrun  out  1  one-cycle pulse; iVsync arrived before the frame finished.
- oBusy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, WAIT_VSYNC, WAIT_LINE, CLR, ARM, RUN.
- IDLE: when iEnable = 1, go to WAIT_VSYNC.
- WAIT_VSYNC: on iVsync:
  - active_base <= shadow_base; oStart_address <= shadow_base; oLine <= 0.
  - Go to WAIT_LINE.
- WAIT_LINE: when iLine_req = 1, go to CLR.
- CLR: oMaster_clr = 1 for exactly this cycle, then go to ARM.
- ARM: oMaster_start <= 1, then go to RUN.
- RUN: oMaster_start stays 1 until iMaster_done = 1. On done:
  - oMaster_start <= 0.
  - If oLine == LINES-1: pulse oFrame_done; go to WAIT_VSYNC if iEnable = 1, else IDLE.
  - Otherwise: oLine += 1; oStart_address += STRIDE; go to WAIT_LINE.
  - If iEnable = 0 mid-frame, go to IDLE instead of WAIT_LINE.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no error. oLine is 12-bit.
- Shadow base:
  - Updated on any iFrame_base_valid, in any state.
  - Copied to active only on an accepted iVsync, so there is no tearing mid-frame.
  - If iFrame_base_valid and iVsync occur in the same cycle, the new value is written to the shadow and the old shadow goes to active; the new base applies from the next frame.
- Underrun: iVsync while in WAIT_LINE, CLR, ARM or RUN:
  - Pulse oUnderrun and oMaster_clr; drop oMaster_start.
  - Reload active base from shadow, set oLine <= 0, go to WAIT_LINE.
  - The new frame starts without waiting for another vsync.
- iMaster_done outside RUN is ignored.

## Timing
- Reset values: all outputs 0 except oLength = LINE_BYTES; state IDLE; shadow and active bases 0.
- iReset mid-line: the sequencer is in IDLE next cycle and oMaster_start = 0. The master is reset by the same iReset.
- iLine_req high in WAIT_LINE → oMaster_clr high 1 cycle later → oMaster_start high 2 cycles later. oStart_address is stable from CLR through RUN.
- iMaster_done → oMaster_start low and oStart_address/oLine updated at the next edge. The earliest next clear is 2 cycles after done.
- oFrame_done and oUnderrun are single-cycle registered pulses.
- One line is in flight at a time; no request pipelining across lines.

## Structure
- Shared package hdmi_pkg holds: state encoding (3-bit enum), default LINE_BYTES/STRIDE/LINES for 640x480x32bpp, and the 12-bit line-count width.
- No sub-module is needed. A single FSM plus address and line counters gives about 150–200 lines of RTL.
- The top level instantiates this block next to the read master.

## Test plan
- Basic frame, LINES=3, STRIDE=0x100:
  - Stimulus: shadow 0x1000; iVsync; iLine_req held high; master model asserts done 20 cycles after start.
  - Required: starts at 0x1000, 0x1100, 0x1200; three oMaster_clr pulses; oFrame_done once; then WAIT_VSYNC.
- Buffer swap: iFrame_base 0x8000 strobed mid-frame → current frame addresses unchanged; next frame begins at 0x8000.
- Underrun: iVsync during line 1 of 3 → oUnderrun = 1 for 1 cycle and oMaster_clr pulse; next start address is the base with oLine = 0.
- Backpressure: iLine_req low for 50 cycles between lines → no oMaster_clr and no start during the gap; address unchanged.
- Wrap: base 0xFFFFFF00, STRIDE 0x100 → second line starts at 0x00000000.
- Reset mid-RUN: iReset for 1 cycle → all outputs at reset values; iVsync with iEnable = 0 causes no activity.

Source files
------------

// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_pkg
// Brief    : Shared types and defaults for the HDMI line read sequencer.
// Revision : 1.0
// ============================================================================
package hdmi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_VSYNC = 3'd1,
        ST_WAIT_LINE  = 3'd2,
        ST_CLR        = 3'd3,
        ST_ARM        = 3'd4,
        ST_RUN        = 3'd5
    } seqState_t;

    // 640x480 at 32 bits per pixel.
    localparam int unsigned c_DEF_LINE_BYTES = 2560;
    localparam int unsigned c_DEF_STRIDE     = 2560;
    localparam int unsigned c_DEF_LINES      = 480;

    localparam int unsigned c_LINE_CNT_W     = 12;

endpackage
`default_nettype wire

// File: rtl/hdmi_line_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_line_read_sequencer
// Brief    : Splits a frame into per-line read-master bursts, one line in
//            flight at a time, with a double-buffered frame base address.
// Revision : 1.0
// ============================================================================
module hdmi_line_read_sequencer
    import hdmi_pkg::*;
#(
    parameter int unsigned LINE_BYTES = c_DEF_LINE_BYTES,
    parameter int unsigned STRIDE     = c_DEF_STRIDE,
    parameter int unsigned LINES      = c_DEF_LINES
) (
    input  logic                    iClk,
    input  logic                    iReset,
    input  logic                    iEnable,
    input  logic [31:0]             iFrame_base,
    input  logic                    iFrame_base_valid,
    input  logic                    iVsync,
    input  logic                    iLine_req,
    input  logic                    iMaster_done,
    output logic                    oMaster_clr,
    output logic                    oMaster_start,
    output logic [31:0]             oStart_address,
    output logic [31:0]             oLength,
    output logic [c_LINE_CNT_W-1:0] oLine,
    output logic                    oFrame_done,
    output logic                    oUnderrun,
    output logic                    oBusy
);

    localparam logic [c_LINE_CNT_W-1:0] c_LAST_LINE = c_LINE_CNT_W'(LINES - 1);
    localparam logic [c_LINE_CNT_W-1:0] c_LINE_ONE  = c_LINE_CNT_W'(1);
    localparam logic [31:0]             c_STRIDE    = 32'(STRIDE);

    seqState_t                 r_state;
    seqState_t                 w_nextState;
    logic [31:0]               r_shadowBase;
    logic [31:0]               r_startAddress;
    logic [c_LINE_CNT_W-1:0]   r_line;
    logic                      r_masterClr;
    logic                      r_masterStart;
    logic                      r_frameDone;
    logic                      r_underrun;

    logic                      w_inFrame;
    logic                      w_underrun;
    logic                      w_frameStart;
    logic                      w_lineDone;
    logic                      w_lastLine;

    // A vsync while a frame is still being fetched aborts it and restarts.
    assign w_inFrame    = (r_state == ST_WAIT_LINE) || (r_state == ST_CLR) ||
                          (r_state == ST_ARM)       || (r_state == ST_RUN);
    assign w_underrun   = iVsync && w_inFrame;
    assign w_frameStart = (iVsync && (r_state == ST_WAIT_VSYNC)) || w_underrun;
    assign w_lineDone   = (r_state == ST_RUN) && iMaster_done && !w_underrun;
    assign w_lastLine   = (r_line == c_LAST_LINE);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (iEnable) begin
                    w_nextState = ST_WAIT_VSYNC;
                end
            end
            ST_WAIT_VSYNC: begin
                if (iVsync) begin
                    w_nextState = ST_WAIT_LINE;
                end
            end
            ST_WAIT_LINE: begin
                if (iLine_req) begin
                    w_nextState = ST_CLR;
                end
            end
            ST_CLR: begin
                w_nextState = ST_ARM;
            end
            ST_ARM: begin
                w_nextState = ST_RUN;
            end
            ST_RUN: begin
                if (iMaster_done) begin
                    if (!iEnable) begin
                        w_nextState = ST_IDLE;
                    end else if (w_lastLine) begin
                        w_nextState = ST_WAIT_VSYNC;
                    end else begin
                        w_nextState = ST_WAIT_LINE;
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (w_underrun) begin
            w_nextState = ST_WAIT_LINE;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state        <= ST_IDLE;
            r_shadowBase   <= 32'd0;
            r_startAddress <= 32'd0;
            r_line         <= '0;
            r_masterClr    <= 1'b0;
            r_masterStart  <= 1'b0;
            r_frameDone    <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (iFrame_base_valid) begin
                r_shadowBase <= iFrame_base;
            end

            // Start is held from ARM until the master reports done.
            r_masterClr   <= (w_nextState == ST_CLR) || w_underrun;
            r_masterStart <= (w_nextState == ST_ARM) || (w_nextState == ST_RUN);
            r_frameDone   <= w_lineDone && w_lastLine;
            r_underrun    <= w_underrun;

            // The shadow read here is the pre-strobe value, so a base written
            // in the same cycle as vsync only applies to the following frame.
            if (w_frameStart) begin
                r_startAddress <= r_shadowBase;
                r_line         <= '0;
            end else if (w_lineDone && !w_lastLine) begin
                r_startAddress <= r_startAddress + c_STRIDE;
                r_line         <= r_line + c_LINE_ONE;
            end
        end
    end

    assign oMaster_clr    = r_masterClr;
    assign oMaster_start  = r_masterStart;
    assign oStart_address = r_startAddress;
    assign oLength        = 32'(LINE_BYTES);
    assign oLine          = r_line;
    assign oFrame_done    = r_frameDone;
    assign oUnderrun      = r_underrun;
    assign oBusy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hdmi_line_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_line_read_sequencer
// Brief    : Directed and randomized checks of the line read sequencer
//            against a frame-level address model and a read-master model.
// Revision : 1.0
// ============================================================================
module tb_hdmi_line_read_sequencer;

    localparam int unsigned P_LINE_BYTES = 64;
    localparam int unsigned P_STRIDE     = 256;
    localparam int unsigned P_LINES      = 3;

    logic        iClk = 1'b0;
    logic        iReset = 1'b1;
    logic        iEnable = 1'b0;
    logic [31:0] iFrame_base = 32'd0;
    logic        iFrame_base_valid = 1'b0;
    logic        iVsync = 1'b0;
    logic        iLine_req = 1'b0;
    logic        iMaster_done = 1'b0;
    logic        oMaster_clr;
    logic        oMaster_start;
    logic [31:0] oStart_address;
    logic [31:0] oLength;
    logic [11:0] oLine;
    logic        oFrame_done;
    logic        oUnderrun;
    logic        oBusy;

    always #5 iClk = ~iClk;

    hdmi_line_read_sequencer #(
        .LINE_BYTES (P_LINE_BYTES),
        .STRIDE     (P_STRIDE),
        .LINES      (P_LINES)
    ) dut (
        .iClk              (iClk),
        .iReset            (iReset),
        .iEnable           (iEnable),
        .iFrame_base       (iFrame_base),
        .iFrame_base_valid (iFrame_base_valid),
        .iVsync            (iVsync),
        .iLine_req         (iLine_req),
        .iMaster_done      (iMaster_done),
        .oMaster_clr       (oMaster_clr),
        .oMaster_start     (oMaster_start),
        .oStart_address    (oStart_address),
        .oLength           (oLength),
        .oLine             (oLine),
        .oFrame_done       (oFrame_done),
        .oUnderrun         (oUnderrun),
        .oBusy             (oBusy)
    );

    int testsRun  = 0;
    int failCount = 0;
    int doneDelay = 20;

    int mCnt  = 0;
    bit mSent = 1'b0;

    logic [31:0] startAddrQ[$];
    logic [31:0] startLineQ[$];
    int clrCnt = 0, fdCnt = 0, urCnt = 0, urNoClr = 0, latErr = 0;
    int fdRun = 0, fdMaxW = 0, urRun = 0, urMaxW = 0;
    logic prevStart = 1'b0, prevClr = 1'b0;

    logic [31:0] mShadow = 32'd0;
    logic [31:0] mActive = 32'd0;

    // Read-master model: one-cycle done a fixed number of cycles after start.
    always @(negedge iClk) begin
        iMaster_done = 1'b0;
        if (!oMaster_start) begin
            mCnt  = 0;
            mSent = 1'b0;
        end else if (!mSent) begin
            mCnt++;
            if (mCnt >= doneDelay) begin
                iMaster_done = 1'b1;
                mSent        = 1'b1;
            end
        end
    end

    always @(negedge iClk) begin
        if (oMaster_clr) clrCnt++;
        if (oFrame_done) begin
            fdCnt++;
            fdRun++;
            if (fdRun > fdMaxW) fdMaxW = fdRun;
        end else begin
            fdRun = 0;
        end
        if (oUnderrun) begin
            urCnt++;
            urRun++;
            if (urRun > urMaxW) urMaxW = urRun;
            if (!oMaster_clr) urNoClr++;
        end else begin
            urRun = 0;
        end
        if (oMaster_start && !prevStart) begin
            startAddrQ.push_back(oStart_address);
            startLineQ.push_back(32'(oLine));
            if (!prevClr) latErr++;
        end
        prevStart = oMaster_start;
        prevClr   = oMaster_clr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic set_base(input logic [31:0] b);
        iFrame_base       = b;
        iFrame_base_valid = 1'b1;
        tick(1);
        iFrame_base_valid = 1'b0;
        mShadow           = b;
    endtask

    task automatic clear_q();
        startAddrQ.delete();
        startLineQ.delete();
    endtask

    // Accepted vsync: the model's active base takes the current shadow.
    task automatic vsync_pulse();
        iVsync  = 1'b1;
        mActive = mShadow;
        tick(1);
        iVsync  = 1'b0;
    endtask

    task automatic wait_fd(input int target, input string tag);
        int n = 0;
        while (fdCnt < target && n < 4000) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(fdCnt >= target), 32'd1);
    endtask

    task automatic wait_starts(input int k, input string tag);
        int n = 0;
        while (startAddrQ.size() < k && n < 1000) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(startAddrQ.size() >= k), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] base);
        chk({tag, "_count"}, 32'(startAddrQ.size()), 32'(P_LINES));
        for (int i = 0; i < int'(P_LINES); i++) begin
            if (i < startAddrQ.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), startAddrQ[i], base + 32'(i) * 32'(P_STRIDE));
                chk($sformatf("%s_line%0d", tag, i), startLineQ[i], 32'(i));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_clr"},    32'(oMaster_clr),   32'd0);
        chk({tag, "_start"},  32'(oMaster_start), 32'd0);
        chk({tag, "_addr"},   oStart_address,     32'd0);
        chk({tag, "_len"},    oLength,            32'(P_LINE_BYTES));
        chk({tag, "_line"},   32'(oLine),         32'd0);
        chk({tag, "_fdone"},  32'(oFrame_done),   32'd0);
        chk({tag, "_urun"},   32'(oUnderrun),     32'd0);
        chk({tag, "_busy"},   32'(oBusy),         32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", testsRun);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, fd0, ur0, n, bad;
        logic [31:0] rb;

        tick(3);
        check_reset_outputs("reset");
        iReset = 1'b0;
        tick(2);
        chk("idle_no_enable_busy", 32'(oBusy), 32'd0);

        // Basic frame.
        doneDelay = 20;
        set_base(32'h0000_1000);
        iEnable = 1'b1;
        tick(2);
        chk("wait_vsync_busy", 32'(oBusy), 32'd1);
        iLine_req = 1'b1;
        clear_q();
        c0  = clrCnt;
        fd0 = fdCnt;
        vsync_pulse();
        wait_fd(fd0 + 1, "basic_done_seen");
        tick(10);
        check_frame("basic", mActive);
        chk("basic_addr0_const", startAddrQ.size() > 0 ? startAddrQ[0] : 32'hDEAD_BEEF, 32'h0000_1000);
        chk("basic_clr_pulses", 32'(clrCnt - c0), 32'(P_LINES));
        chk("basic_fdone_once", 32'(fdCnt - fd0), 32'd1);
        chk("basic_after_start", 32'(oMaster_start), 32'd0);
        chk("basic_after_busy", 32'(oBusy), 32'd1);

        // Buffer swap mid-frame, then a base strobe coincident with vsync.
        doneDelay = $urandom_range(5, 25);
        clear_q();
        fd0 = fdCnt;
        vsync_pulse();
        wait_starts(1, "swap_first_start");
        set_base(32'h0000_8000);
        wait_fd(fd0 + 1, "swap_done_seen");
        check_frame("swap_cur", mActive);
        clear_q();
        fd0 = fdCnt;
        iFrame_base       = 32'h0000_A000;
        iFrame_base_valid = 1'b1;
        iVsync            = 1'b1;
        mActive           = mShadow;
        mShadow           = 32'h0000_A000;
        tick(1);
        iVsync            = 1'b0;
        iFrame_base_valid = 1'b0;
        wait_fd(fd0 + 1, "swap_next_done_seen");
        check_frame("swap_next", mActive);
        chk("swap_next_base", startAddrQ.size() > 0 ? startAddrQ[0] : 32'hDEAD_BEEF, 32'h0000_8000);

        // Underrun: vsync during line 1.
        doneDelay = 20;
        clear_q();
        fd0 = fdCnt;
        vsync_pulse();
        wait_starts(2, "underrun_second_start");
        ur0 = urCnt;
        clear_q();
        vsync_pulse();
        wait_fd(fd0 + 1, "underrun_done_seen");
        check_frame("underrun", mActive);
        chk("underrun_pulses", 32'(urCnt - ur0), 32'd1);
        chk("underrun_width", 32'(urMaxW), 32'd1);
        chk("underrun_with_clr", 32'(urNoClr), 32'd0);

        // Backpressure: line request withheld between lines 0 and 1.
        set_base(32'h0000_2000);
        clear_q();
        fd0 = fdCnt;
        vsync_pulse();
        wait_starts(1, "bp_first_start");
        iLine_req = 1'b0;
        n = 0;
        while (oMaster_start && n < 200) begin
            tick(1);
            n++;
        end
        chk("bp_line0_finished", 32'(oMaster_start), 32'd0);
        c0  = clrCnt;
        bad = 0;
        repeat (50) begin
            tick(1);
            if (oMaster_start || oMaster_clr) bad++;
        end
        chk("bp_gap_activity", 32'(bad), 32'd0);
        chk("bp_gap_clr", 32'(clrCnt - c0), 32'd0);
        chk("bp_gap_starts", 32'(startAddrQ.size()), 32'd1);
        chk("bp_gap_addr", oStart_address, mActive + 32'(P_STRIDE));
        chk("bp_gap_line", 32'(oLine), 32'd1);
        iLine_req = 1'b1;
        wait_fd(fd0 + 1, "bp_done_seen");
        check_frame("bp", mActive);

        // Address wrap.
        set_base(32'hFFFF_FF00);
        clear_q();
        fd0 = fdCnt;
        vsync_pulse();
        wait_fd(fd0 + 1, "wrap_done_seen");
        check_frame("wrap", mActive);
        chk("wrap_line1_zero", startAddrQ.size() > 1 ? startAddrQ[1] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Randomized frames with random bases, latencies and line-request gaps.
        for (int f = 0; f < 3; f++) begin
            rb = $urandom & 32'hFFFF_FFFC;
            set_base(rb);
            doneDelay = $urandom_range(3, 25);
            clear_q();
            fd0 = fdCnt;
            vsync_pulse();
            n = 0;
            while (fdCnt < fd0 + 1 && n < 4000) begin
                iLine_req = ($urandom_range(0, 3) != 0);
                tick(1);
                n++;
            end
            iLine_req = 1'b1;
            chk($sformatf("rand%0d_done_seen", f), 32'(fdCnt >= fd0 + 1), 32'd1);
            check_frame($sformatf("rand%0d", f), mActive);
        end

        // Reset in the middle of a line; vsync afterwards with enable low.
        doneDelay = 20;
        clear_q();
        vsync_pulse();
        wait_starts(1, "rst_first_start");
        tick(2);
        iEnable = 1'b0;
        iReset  = 1'b1;
        tick(1);
        iReset  = 1'b0;
        check_reset_outputs("midrun_reset");
        clear_q();
        c0 = clrCnt;
        iVsync = 1'b1;
        tick(1);
        iVsync = 1'b0;
        tick(30);
        chk("post_reset_clr", 32'(clrCnt - c0), 32'd0);
        chk("post_reset_starts", 32'(startAddrQ.size()), 32'd0);
        chk("post_reset_busy", 32'(oBusy), 32'd0);

        chk("clr_to_start_latency", 32'(latErr), 32'd0);
        chk("fdone_width", 32'(fdMaxW), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
`default_nettype wire
